mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Two-requester arbiter sharing the single data-memory port (pmem read/write path) between IFU (master 0) and LSU (master 1).
- Sits between the IFU/LSU and the memory access block.
- Serialises one transaction at a time with valid/ready handshakes and round-robin grant.
- Watchdog counter flags responses that never arrive.

Parameters:
- AW, 32, address width
- DW, 32, data width
- MW, 8, write byte-mask width
- TIMEOUT, 255, cycles to wait for mem_rvalid before forcing an error response (1..65535)

Ports:
- clk  in  1  clock, all state updates on posedge
- rst_n  in  1  asynchronous active-low reset
- m_req_valid  in  2  per-master request valid, bit0=IFU, bit1=LSU
- m_req_ready  out  2  per-master request accepted
- m_req_wen  in  2  per-master write enable
- m_req_addr  in  2*AW  per-master address, [AW-1:0]=IFU
- m_req_wdata  in  2*DW  per-master write data
- m_req_wmask  in  2*MW  per-master byte mask
- m_resp_valid  out  2  per-master response valid
- m_resp_ready  in  2  per-master response accept
- m_resp_rdata  out  DW  response read data, shared by both masters
- m_resp_err  out  1  response is a timeout error
- mem_valid  out  1  downstream request valid
- mem_ready  in  1  downstream request accepted
- mem_wen  out  1  downstream write enable
- mem_addr  out  AW  downstream address
- mem_wdata  out  DW  downstream write data
- mem_wmask  out  MW  downstream byte mask
- mem_rvalid  in  1  downstream response valid (reads and writes both respond)
- mem_rdata  in  DW  downstream read data
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst_n=0):
  - State=IDLE; last_grant=0 (IFU), so LSU wins the first tie.
  - All outputs 0; watchdog counter 0; latched request registers 0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any m_req_valid, choose grant g: a single requester wins; with both requesting, g = ~last_grant.
  - Assert m_req_ready[g] for exactly that cycle (combinational from m_req_valid and state).
  - Latch wen, addr, wdata and wmask of g; set last_grant=g; go to ISSUE.
  - m_req_ready is never asserted outside IDLE and never for both bits at once.
- ISSUE:
  - mem_valid=1 with the latched fields, held stable until mem_ready.
  - On mem_ready go to WAIT and clear the watchdog.
  - mem_ready and mem_rvalid in the same cycle: capture mem_rdata and go directly to RESP.
- WAIT:
  - Watchdog increments each cycle.
  - On mem_rvalid: capture rdata and set err=0, go to RESP.
  - Counter reaches TIMEOUT-1 without mem_rvalid: rdata=0, err=1, go to RESP.
  - A mem_rvalid arriving after the timeout is ignored.
- RESP:
  - m_resp_valid[g]=1 with m_resp_rdata/m_resp_err held stable.
  - On m_resp_ready[g] go to IDLE.
  - Response-side backpressure is unbounded; no watchdog runs in RESP.
- Latency: request-accept to mem_valid = 1 cycle; mem_rvalid to m_resp_valid = 1 cycle. Zero-wait memory gives a 3-cycle minimum transaction (IDLE, ISSUE, RESP).
- The loser's m_req_valid may stay high; it is granted on the next IDLE visit.
- Masters must hold request fields stable until ready, per the valid/ready convention.
- Write transactions return a response; m_resp_rdata is don't-care and err is valid.
- The watchdog counter is $clog2(TIMEOUT+1) bits wide and saturates, never wraps.
- Reset mid-transaction aborts immediately to IDLE; downstream side effects already issued are not undone.
- busy = (state != IDLE).

Test Plan:
- Reset, then only IFU reads addr 0x80000000, memory returns 0x00000413 after 2 cycles -> m_req_ready=2'b01 one cycle; mem_addr=0x80000000, mem_wen=0; m_resp_valid=2'b01, rdata=0x00000413, err=0.
- Both request in the same cycle right after reset -> LSU granted first, IFU second, LSU third with both held; grants alternate strictly.
- LSU write addr 0x80001000, wdata 0xDEADBEEF, wmask 0x0F, mem_ready delayed 3 cycles -> mem_* fields held stable 3 cycles; one response to LSU with err=0.
- Memory never asserts mem_rvalid, TIMEOUT=8 -> m_resp_valid after exactly 8 WAIT cycles, rdata=0, err=1; a late mem_rvalid has no effect.
- m_resp_ready held low 5 cycles -> response held stable; no new m_req_ready asserted until handshake completes.
- rst_n pulsed low during WAIT -> all outputs 0 asynchronously; next request proceeds normally, with LSU winning the next tie.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one data-memory port between the IFU (master 0) and the
// LSU (master 1). One transaction is in flight at a time. Ties are broken
// round-robin, and a watchdog turns a missing memory response into an error.
//
// Ports:
//   clk, rst_n        clock; asynchronous active-low reset
//   m_req_*           per-master request channel (bit/slice 0 = IFU, 1 = LSU)
//   m_resp_*          per-master response channel; rdata/err shared by both
//   mem_*             downstream memory request and response
//   busy              high whenever a transaction is in progress
module mem_arbiter #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned MW      = 8,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  // Master request side
  input  logic [1:0]      m_req_valid,
  output logic [1:0]      m_req_ready,
  input  logic [1:0]      m_req_wen,
  input  logic [2*AW-1:0] m_req_addr,
  input  logic [2*DW-1:0] m_req_wdata,
  input  logic [2*MW-1:0] m_req_wmask,
  // Master response side
  output logic [1:0]      m_resp_valid,
  input  logic [1:0]      m_resp_ready,
  output logic [DW-1:0]   m_resp_rdata,
  output logic            m_resp_err,
  // Downstream memory
  output logic            mem_valid,
  input  logic            mem_ready,
  output logic            mem_wen,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [MW-1:0]   mem_wmask,
  input  logic            mem_rvalid,
  input  logic [DW-1:0]   mem_rdata,
  // Status
  output logic            busy
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);
  localparam logic [CntW-1:0] CntMax  = {CntW{1'b1}};

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } state_e;

  state_e          state_q, state_d;
  logic            last_grant_q, last_grant_d;
  logic            wen_q, wen_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [MW-1:0]   wmask_q, wmask_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            err_q, err_d;
  logic [CntW-1:0] wdog_q, wdog_d;

  logic            grant;

  // Arbitration: a lone requester always wins; on a tie the master that was
  // not served last goes next. last_grant_q also routes the response, since it
  // holds the owner of the transaction currently in flight.
  always_comb begin
    grant = last_grant_q;
    case (m_req_valid)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~last_grant_q;
      default: grant = last_grant_q;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    wen_d        = wen_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wmask_d      = wmask_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    wdog_d       = wdog_q;
    m_req_ready  = 2'b00;
    m_resp_valid = 2'b00;
    mem_valid    = 1'b0;

    case (state_q)
      StIdle: begin
        if (m_req_valid != 2'b00) begin
          m_req_ready  = grant ? 2'b10 : 2'b01;
          last_grant_d = grant;
          wen_d        = m_req_wen[grant];
          addr_d       = grant ? m_req_addr[2*AW-1:AW]  : m_req_addr[AW-1:0];
          wdata_d      = grant ? m_req_wdata[2*DW-1:DW] : m_req_wdata[DW-1:0];
          wmask_d      = grant ? m_req_wmask[2*MW-1:MW] : m_req_wmask[MW-1:0];
          state_d      = StIssue;
        end
      end

      StIssue: begin
        mem_valid = 1'b1;
        if (mem_ready) begin
          wdog_d = '0;
          // Memory may accept and answer in the same cycle.
          if (mem_rvalid) begin
            rdata_d = mem_rdata;
            err_d   = 1'b0;
            state_d = StResp;
          end else begin
            state_d = StWait;
          end
        end
      end

      StWait: begin
        if (mem_rvalid) begin
          rdata_d = mem_rdata;
          err_d   = 1'b0;
          state_d = StResp;
        end else if (wdog_q == CntLast) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = StResp;
        end else if (wdog_q != CntMax) begin
          wdog_d = wdog_q + CntW'(1);
        end
      end

      StResp: begin
        // No watchdog here: a master may stall its response indefinitely.
        m_resp_valid = last_grant_q ? 2'b10 : 2'b01;
        if (m_resp_ready[last_grant_q]) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b0;
      wen_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wmask_q      <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      wdog_q       <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      wen_q        <= wen_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wmask_q      <= wmask_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
      wdog_q       <= wdog_d;
    end
  end

  assign mem_wen      = wen_q;
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
  assign mem_wmask    = wmask_q;
  assign m_resp_rdata = rdata_q;
  assign m_resp_err   = err_q;
  assign busy         = (state_q != StIdle);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: table of round-robin transactions plus
// hand-written sequences for stalls, timeout, backpressure and mid-flight reset.
module tb_mem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned MW = 8;
  localparam int unsigned TO = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [1:0]      m_req_valid;
  logic [1:0]      m_req_ready;
  logic [1:0]      m_req_wen;
  logic [2*AW-1:0] m_req_addr;
  logic [2*DW-1:0] m_req_wdata;
  logic [2*MW-1:0] m_req_wmask;
  logic [1:0]      m_resp_valid;
  logic [1:0]      m_resp_ready;
  logic [DW-1:0]   m_resp_rdata;
  logic            m_resp_err;
  logic            mem_valid;
  logic            mem_ready;
  logic            mem_wen;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [MW-1:0]   mem_wmask;
  logic            mem_rvalid;
  logic [DW-1:0]   mem_rdata;
  logic            busy;

  int n_checks = 0;
  int n_fail   = 0;

  mem_arbiter #(
    .AW     (AW),
    .DW     (DW),
    .MW     (MW),
    .TIMEOUT(TO)
  ) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .m_req_valid (m_req_valid),
    .m_req_ready (m_req_ready),
    .m_req_wen   (m_req_wen),
    .m_req_addr  (m_req_addr),
    .m_req_wdata (m_req_wdata),
    .m_req_wmask (m_req_wmask),
    .m_resp_valid(m_resp_valid),
    .m_resp_ready(m_resp_ready),
    .m_resp_rdata(m_resp_rdata),
    .m_resp_err  (m_resp_err),
    .mem_valid   (mem_valid),
    .mem_ready   (mem_ready),
    .mem_wen     (mem_wen),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_wmask   (mem_wmask),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]    req;
    logic [1:0]    wen;
    logic [AW-1:0] addr0;
    logic [AW-1:0] addr1;
    logic [1:0]    exp_ready;
    logic [AW-1:0] exp_addr;
    logic          exp_wen;
    logic [DW-1:0] rdata;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    m_req_valid  = '0;
    m_req_wen    = '0;
    m_req_addr   = '0;
    m_req_wdata  = '0;
    m_req_wmask  = '0;
    m_resp_ready = '0;
    mem_ready    = 1'b0;
    mem_rvalid   = 1'b0;
    mem_rdata    = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got hang, expected completion");
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic [1:0]    g;
    logic [DW-1:0] exp_wd;
    logic [MW-1:0] exp_wm;

    // Tie table, starting right after reset (last grant = IFU).
    vecs[0] = '{2'b11, 2'b00, 32'h100, 32'h200, 2'b10, 32'h200, 1'b0, 32'h0000_00A1};
    vecs[1] = '{2'b11, 2'b10, 32'h104, 32'h204, 2'b01, 32'h104, 1'b0, 32'h0000_00A2};
    vecs[2] = '{2'b11, 2'b10, 32'h108, 32'h208, 2'b10, 32'h208, 1'b1, 32'h0000_00A3};
    vecs[3] = '{2'b01, 2'b00, 32'h10C, 32'h20C, 2'b01, 32'h10C, 1'b0, 32'h0000_00A4};
    vecs[4] = '{2'b01, 2'b00, 32'h110, 32'h210, 2'b01, 32'h110, 1'b0, 32'h0000_00A5};
    vecs[5] = '{2'b10, 2'b00, 32'h114, 32'h214, 2'b10, 32'h214, 1'b0, 32'h0000_00A6};
    vecs[6] = '{2'b11, 2'b01, 32'h118, 32'h218, 2'b01, 32'h118, 1'b1, 32'h0000_00A7};
    vecs[7] = '{2'b11, 2'b00, 32'h11C, 32'h21C, 2'b10, 32'h21C, 1'b0, 32'h0000_00A8};

    // ---- Reset state
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 64'(m_req_ready), 64'h0);
    chk("rst_resp_valid", 64'(m_resp_valid), 64'h0);
    chk("rst_mem_valid", 64'(mem_valid), 64'h0);
    chk("rst_mem_addr", 64'(mem_addr), 64'h0);
    chk("rst_resp_err", 64'(m_resp_err), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // ---- IFU read, 2-cycle memory latency, then response backpressure
    m_req_valid = 2'b01;
    m_req_addr[AW-1:0] = 32'h8000_0000;
    mid();
    chk("ifu_req_ready", 64'(m_req_ready), 64'h1);
    chk("ifu_busy_idle", 64'(busy), 64'h0);
    tick();
    m_req_valid = 2'b00;
    mem_ready   = 1'b1;
    mid();
    chk("ifu_mem_valid", 64'(mem_valid), 64'h1);
    chk("ifu_mem_addr", 64'(mem_addr), 64'h8000_0000);
    chk("ifu_mem_wen", 64'(mem_wen), 64'h0);
    chk("ifu_req_ready_issue", 64'(m_req_ready), 64'h0);
    tick();
    mem_ready = 1'b0;
    mid();
    chk("ifu_wait_mem_valid", 64'(mem_valid), 64'h0);
    chk("ifu_wait_busy", 64'(busy), 64'h1);
    tick();
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h0000_0413;
    tick();
    mem_rvalid = 1'b0;
    mem_rdata  = 32'hFFFF_FFFF;
    m_req_valid = 2'b10;
    m_req_addr[2*AW-1:AW] = 32'h8000_0040;
    for (int k = 0; k < 5; k++) begin
      mid();
      chk("bp_resp_valid", 64'(m_resp_valid), 64'h1);
      chk("bp_resp_rdata", 64'(m_resp_rdata), 64'h413);
      chk("bp_resp_err", 64'(m_resp_err), 64'h0);
      chk("bp_req_ready", 64'(m_req_ready), 64'h0);
      tick();
    end
    m_resp_ready = 2'b01;
    mid();
    chk("bp_resp_valid_hs", 64'(m_resp_valid), 64'h1);
    tick();
    m_resp_ready = 2'b00;
    m_req_valid  = 2'b00;
    mid();
    chk("ifu_back_idle", 64'(busy), 64'h0);
    chk("ifu_resp_dropped", 64'(m_resp_valid), 64'h0);
    tick();

    // ---- Round-robin table, zero-wait memory, right after reset
    do_reset();
    for (int i = 0; i < 8; i++) begin
      g = vecs[i].exp_ready;
      exp_wd = (g == 2'b10) ? (32'h1D1D_0000 | i) : (32'h0D0D_0000 | i);
      exp_wm = (g == 2'b10) ? 8'hF0 : 8'h0F;
      m_req_valid = vecs[i].req;
      m_req_wen   = vecs[i].wen;
      m_req_addr  = {vecs[i].addr1, vecs[i].addr0};
      m_req_wdata = {32'h1D1D_0000 | i, 32'h0D0D_0000 | i};
      m_req_wmask = {8'hF0, 8'h0F};
      mem_rdata   = vecs[i].rdata;
      mid();
      chk("tbl_req_ready", 64'(m_req_ready), 64'(vecs[i].exp_ready));
      tick();
      mem_ready  = 1'b1;
      mem_rvalid = 1'b1;
      mid();
      chk("tbl_mem_valid", 64'(mem_valid), 64'h1);
      chk("tbl_mem_addr", 64'(mem_addr), 64'(vecs[i].exp_addr));
      chk("tbl_mem_wen", 64'(mem_wen), 64'(vecs[i].exp_wen));
      chk("tbl_mem_wdata", 64'(mem_wdata), 64'(exp_wd));
      chk("tbl_mem_wmask", 64'(mem_wmask), 64'(exp_wm));
      chk("tbl_req_ready_held", 64'(m_req_ready), 64'h0);
      tick();
      mem_ready    = 1'b0;
      mem_rvalid   = 1'b0;
      m_resp_ready = 2'b11;
      mid();
      chk("tbl_resp_valid", 64'(m_resp_valid), 64'(vecs[i].exp_ready));
      chk("tbl_resp_rdata", 64'(m_resp_rdata), 64'(vecs[i].rdata));
      chk("tbl_resp_err", 64'(m_resp_err), 64'h0);
      tick();
      m_resp_ready = 2'b00;
    end
    m_req_valid = 2'b00;
    m_req_wen   = 2'b00;

    // ---- LSU write with mem_ready stalled 3 cycles
    m_req_valid = 2'b10;
    m_req_wen   = 2'b10;
    m_req_addr[2*AW-1:AW]  = 32'h8000_1000;
    m_req_wdata[2*DW-1:DW] = 32'hDEAD_BEEF;
    m_req_wmask[2*MW-1:MW] = 8'h0F;
    mid();
    chk("wr_req_ready", 64'(m_req_ready), 64'h2);
    tick();
    m_req_valid = 2'b00;
    m_req_wen   = 2'b00;
    m_req_addr  = '0;
    m_req_wdata = '0;
    m_req_wmask = '0;
    for (int k = 0; k < 3; k++) begin
      mid();
      chk("wr_stall_valid", 64'(mem_valid), 64'h1);
      chk("wr_stall_addr", 64'(mem_addr), 64'h8000_1000);
      chk("wr_stall_wdata", 64'(mem_wdata), 64'hDEAD_BEEF);
      chk("wr_stall_wmask", 64'(mem_wmask), 64'h0F);
      chk("wr_stall_wen", 64'(mem_wen), 64'h1);
      tick();
    end
    mem_ready = 1'b1;
    mid();
    chk("wr_accept_valid", 64'(mem_valid), 64'h1);
    tick();
    mem_ready = 1'b0;
    mid();
    chk("wr_wait_valid", 64'(mem_valid), 64'h0);
    chk("wr_wait_resp", 64'(m_resp_valid), 64'h0);
    tick();
    mem_rvalid = 1'b1;
    tick();
    mem_rvalid = 1'b0;
    mid();
    chk("wr_resp_valid", 64'(m_resp_valid), 64'h2);
    chk("wr_resp_err", 64'(m_resp_err), 64'h0);
    m_resp_ready = 2'b10;
    tick();
    m_resp_ready = 2'b00;
    mid();
    chk("wr_single_resp", 64'(m_resp_valid), 64'h0);
    tick();

    // ---- Timeout: memory accepts but never answers
    m_req_valid = 2'b01;
    m_req_addr[AW-1:0] = 32'h8000_0100;
    mem_rdata = 32'hFFFF_FFFF;
    tick();
    m_req_valid = 2'b00;
    mem_ready   = 1'b1;
    tick();
    mem_ready = 1'b0;
    for (int k = 0; k < int'(TO); k++) begin
      mid();
      chk("to_wait_no_resp", 64'(m_resp_valid), 64'h0);
      chk("to_wait_busy", 64'(busy), 64'h1);
      tick();
    end
    mid();
    chk("to_resp_valid", 64'(m_resp_valid), 64'h1);
    chk("to_resp_rdata", 64'(m_resp_rdata), 64'h0);
    chk("to_resp_err", 64'(m_resp_err), 64'h1);
    tick();
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h0000_1234;
    for (int k = 0; k < 2; k++) begin
      mid();
      chk("to_late_valid", 64'(m_resp_valid), 64'h1);
      chk("to_late_rdata", 64'(m_resp_rdata), 64'h0);
      chk("to_late_err", 64'(m_resp_err), 64'h1);
      tick();
    end
    mem_rvalid   = 1'b0;
    m_resp_ready = 2'b01;
    tick();
    m_resp_ready = 2'b00;
    mid();
    chk("to_back_idle", 64'(busy), 64'h0);
    tick();

    // ---- Reset while LSU read is in WAIT (last grant becomes LSU first)
    m_req_valid = 2'b10;
    m_req_addr[2*AW-1:AW] = 32'h8000_2000;
    tick();
    m_req_valid = 2'b00;
    mem_ready   = 1'b1;
    tick();
    mem_ready = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'h0);
    chk("arst_mem_valid", 64'(mem_valid), 64'h0);
    chk("arst_mem_addr", 64'(mem_addr), 64'h0);
    chk("arst_resp_valid", 64'(m_resp_valid), 64'h0);
    chk("arst_req_ready", 64'(m_req_ready), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    m_req_valid = 2'b11;
    m_req_addr  = {32'h8000_3000, 32'h8000_4000};
    mid();
    chk("arst_tie_ready", 64'(m_req_ready), 64'h2);
    tick();
    m_req_valid = 2'b00;
    mem_ready   = 1'b1;
    mem_rvalid  = 1'b1;
    mem_rdata   = 32'h0000_5A5A;
    mid();
    chk("arst_mem_addr2", 64'(mem_addr), 64'h8000_3000);
    tick();
    mem_ready  = 1'b0;
    mem_rvalid = 1'b0;
    mid();
    chk("arst_resp_valid2", 64'(m_resp_valid), 64'h2);
    chk("arst_resp_rdata2", 64'(m_resp_rdata), 64'h5A5A);
    m_resp_ready = 2'b10;
    tick();
    m_resp_ready = 2'b00;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
